// File: rtl/controla_writeback_pkg.sv
// Shared definitions for the writeback arbiter: default widths and the
// queue-occupancy state encoding.
package controla_writeback_pkg;

    localparam int DATA_W_PADRAO    = 32;
    localparam int REG_W_PADRAO     = 5;
    localparam int FILA_PROF_PADRAO = 2;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        DRENANDO = 2'd1,
        CHEIO    = 2'd2
    } estado_t;

    function automatic estado_t estado_de(input int ocupacao, input int prof);
        if (ocupacao == 0)
            return OCIOSO;
        else if (ocupacao >= prof)
            return CHEIO;
        return DRENANDO;
    endfunction

endpackage

// File: rtl/controla_writeback_fila_resultado.sv
// Multiply/divide result FIFO; each slot carries a vivo bit that a
// pipeline write to the same register clears in parallel across all slots.
module fila_resultado #(
    parameter  int DATA_W = 32,
    parameter  int REG_W  = 5,
    parameter  int PROF   = 2,
    localparam int PTR_W  = $clog2(PROF),
    localparam int CNT_W  = $clog2(PROF + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              push_vivo,
    input  logic [REG_W-1:0]  push_reg,
    input  logic [DATA_W-1:0] push_dado,
    input  logic              pop,
    input  logic              kill,
    input  logic [REG_W-1:0]  kill_reg,
    output logic              head_vivo,
    output logic [REG_W-1:0]  head_reg,
    output logic [DATA_W-1:0] head_dado,
    output logic [CNT_W-1:0]  count
);

    logic [PROF-1:0]   vivo;
    logic [REG_W-1:0]  regs  [PROF];
    logic [DATA_W-1:0] dados [PROF];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              push_morto;

    function automatic logic [PTR_W-1:0] avanca(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PROF - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // An entry written in the same cycle as a matching pipeline write is born dead.
    assign push_morto = kill && (push_reg == kill_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            vivo   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < PROF; i++) begin
                if (kill && (regs[i] == kill_reg))
                    vivo[i] <= 1'b0;
            end
            if (push) begin
                vivo[wr_ptr]  <= push_vivo && !push_morto;
                regs[wr_ptr]  <= push_reg;
                dados[wr_ptr] <= push_dado;
                wr_ptr        <= avanca(wr_ptr);
            end
            if (pop)
                rd_ptr <= avanca(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_vivo = vivo[rd_ptr];
    assign head_reg  = regs[rd_ptr];
    assign head_dado = dados[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/controla_writeback.sv
// Register-file write-port arbiter: pipeline writeback first, queued
// multiply/divide results drained in idle cycles, bubble request when full.
module controla_writeback
    import controla_writeback_pkg::*;
#(
    parameter int DATA_W    = DATA_W_PADRAO,
    parameter int REG_W     = REG_W_PADRAO,
    parameter int FILA_PROF = FILA_PROF_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valido,
    input  logic [REG_W-1:0]  wb_regDestino,
    input  logic [DATA_W-1:0] resultadoALU,
    input  logic [DATA_W-1:0] dadoLido,
    input  logic              MemtoReg,
    input  logic              md_valido,
    input  logic [REG_W-1:0]  md_regDestino,
    input  logic [DATA_W-1:0] md_dado,
    output logic              md_pronto,
    output logic              escreveReg,
    output logic [REG_W-1:0]  regEscrita,
    output logic [DATA_W-1:0] dadoEscrita,
    output logic              pedeBolha
);

    localparam int CNT_W = $clog2(FILA_PROF + 1);

    estado_t           estado;
    estado_t           estado_prox;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_prox;
    logic              wb_escreve;
    logic              handshake;
    logic              fila_vazia;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              head_vivo;
    logic [REG_W-1:0]  head_reg;
    logic [DATA_W-1:0] head_dado;
    logic [DATA_W-1:0] dado_pipe;
    logic              sel_en;
    logic [REG_W-1:0]  sel_reg;
    logic [DATA_W-1:0] sel_dado;

    assign dado_pipe  = MemtoReg ? dadoLido : resultadoALU;
    assign wb_escreve = wb_valido && (wb_regDestino != '0);
    assign handshake  = md_valido && md_pronto;
    assign fila_vazia = (count == '0);
    assign pop        = !wb_escreve && !fila_vazia;
    assign bypass     = !wb_escreve && fila_vazia && handshake;
    assign push       = handshake && !bypass;

    fila_resultado #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .PROF   (FILA_PROF)
    ) u_fila (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_vivo (md_regDestino != '0),
        .push_reg  (md_regDestino),
        .push_dado (md_dado),
        .pop       (pop),
        .kill      (wb_escreve),
        .kill_reg  (wb_regDestino),
        .head_vivo (head_vivo),
        .head_reg  (head_reg),
        .head_dado (head_dado),
        .count     (count)
    );

    always_comb begin
        sel_en   = 1'b0;
        sel_reg  = '0;
        sel_dado = '0;
        if (wb_escreve) begin
            sel_en   = 1'b1;
            sel_reg  = wb_regDestino;
            sel_dado = dado_pipe;
        end else if (pop) begin
            // Dead entries still leave the queue, just without a write.
            if (head_vivo) begin
                sel_en   = 1'b1;
                sel_reg  = head_reg;
                sel_dado = head_dado;
            end
        end else if (bypass && (md_regDestino != '0)) begin
            sel_en   = 1'b1;
            sel_reg  = md_regDestino;
            sel_dado = md_dado;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            estado <= OCIOSO;
        else
            estado <= estado_prox;
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_prox = count + CNT_W'(1);
            2'b01:   count_prox = count - CNT_W'(1);
            default: count_prox = count;
        endcase
        estado_prox = estado_de(int'(count_prox), FILA_PROF);
    end

    always_comb begin
        md_pronto = (estado != CHEIO);
        pedeBolha = (estado == CHEIO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            escreveReg  <= 1'b0;
            regEscrita  <= '0;
            dadoEscrita <= '0;
        end else begin
            escreveReg  <= sel_en;
            regEscrita  <= sel_reg;
            dadoEscrita <= sel_dado;
        end
    end

endmodule

// File: tb/tb_controla_writeback.sv
// Bench for controla_writeback: directed scenarios plus randomized traffic
// checked against a queue-based model of the arbitration rules.
module tb_controla_writeback;

    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int PROF = 2;

    logic          clock;
    logic          reset;
    logic          wb_valido;
    logic [RW-1:0] wb_regDestino;
    logic [DW-1:0] resultadoALU;
    logic [DW-1:0] dadoLido;
    logic          MemtoReg;
    logic          md_valido;
    logic [RW-1:0] md_regDestino;
    logic [DW-1:0] md_dado;
    logic          md_pronto;
    logic          escreveReg;
    logic [RW-1:0] regEscrita;
    logic [DW-1:0] dadoEscrita;
    logic          pedeBolha;

    controla_writeback #(.DATA_W(DW), .REG_W(RW), .FILA_PROF(PROF)) dut (
        .clock         (clock),
        .reset         (reset),
        .wb_valido     (wb_valido),
        .wb_regDestino (wb_regDestino),
        .resultadoALU  (resultadoALU),
        .dadoLido      (dadoLido),
        .MemtoReg      (MemtoReg),
        .md_valido     (md_valido),
        .md_regDestino (md_regDestino),
        .md_dado       (md_dado),
        .md_pronto     (md_pronto),
        .escreveReg    (escreveReg),
        .regEscrita    (regEscrita),
        .dadoEscrita   (dadoEscrita),
        .pedeBolha     (pedeBolha)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit            vivo;
        logic [RW-1:0] rg;
        logic [DW-1:0] dado;
    } entrada_t;

    entrada_t      fila[$];
    logic [DW-1:0] rf_modelo [32];
    logic [DW-1:0] rf_dut    [32];
    bit            exp_we;
    logic [RW-1:0] exp_reg;
    logic [DW-1:0] exp_dado;
    bit            exp_bolha;
    bit            ultimo_hs;
    int            total;
    int            bad;

    task automatic drive(input bit wv, input logic [RW-1:0] wr, input logic [DW-1:0] alu,
                         input logic [DW-1:0] ld, input bit m2r, input bit mv,
                         input logic [RW-1:0] mr, input logic [DW-1:0] md);
        wb_valido     = wv;
        wb_regDestino = wr;
        resultadoALU  = alu;
        dadoLido      = ld;
        MemtoReg      = m2r;
        md_valido     = mv;
        md_regDestino = mr;
        md_dado       = md;
    endtask

    // Model one clock of the arbiter from the current inputs, then advance the DUT.
    task automatic step();
        entrada_t e;
        bit pronto, hs, wbw, usado;
        pronto   = fila.size() < PROF;
        hs       = md_valido && pronto;
        wbw      = wb_valido && (wb_regDestino != 0);
        usado    = 1'b0;
        exp_we   = 1'b0;
        exp_reg  = '0;
        exp_dado = '0;
        if (wbw) begin
            exp_we   = 1'b1;
            exp_reg  = wb_regDestino;
            exp_dado = MemtoReg ? dadoLido : resultadoALU;
            for (int i = 0; i < fila.size(); i++)
                if (fila[i].rg == wb_regDestino) fila[i].vivo = 1'b0;
        end else if (fila.size() > 0) begin
            e = fila.pop_front();
            if (e.vivo) begin
                exp_we   = 1'b1;
                exp_reg  = e.rg;
                exp_dado = e.dado;
            end
        end else if (hs) begin
            usado = 1'b1;
            if (md_regDestino != 0) begin
                exp_we   = 1'b1;
                exp_reg  = md_regDestino;
                exp_dado = md_dado;
            end
        end
        if (hs && !usado) begin
            e.vivo = (md_regDestino != 0) && !(wbw && md_regDestino == wb_regDestino);
            e.rg   = md_regDestino;
            e.dado = md_dado;
            fila.push_back(e);
        end
        exp_bolha = (fila.size() == PROF);
        ultimo_hs = hs;
        if (exp_we) rf_modelo[exp_reg] = exp_dado;
        @(posedge clock);
        #1;
        if (escreveReg === 1'b1) rf_dut[regEscrita] = dadoEscrita;
    endtask

    task automatic apply_reset(input int ciclos);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (ciclos) @(posedge clock);
        #1;
        fila.delete();
    endtask

    task automatic test_reset();
        apply_reset(2);
        total++; if (escreveReg !== 1'b0) begin bad++; $display("[TB] FAIL reset_we: got %b want 0", escreveReg); end
        total++; if (regEscrita !== 5'd0) begin bad++; $display("[TB] FAIL reset_reg: got %0d want 0", regEscrita); end
        total++; if (dadoEscrita !== 32'd0) begin bad++; $display("[TB] FAIL reset_dado: got %h want 0", dadoEscrita); end
        total++; if (pedeBolha !== 1'b0) begin bad++; $display("[TB] FAIL reset_bolha: got %b want 0", pedeBolha); end
        total++; if (md_pronto !== 1'b1) begin bad++; $display("[TB] FAIL reset_pronto: got %b want 1", md_pronto); end
        reset = 1'b0;
    endtask

    task automatic test_pipeline();
        drive(1, 5, 32'h11, 32'h99, 0, 0, 0, 0);
        step();
        total++; if (escreveReg !== 1'b1) begin bad++; $display("[TB] FAIL pipe_we: got %b want 1", escreveReg); end
        total++; if (regEscrita !== 5'd5) begin bad++; $display("[TB] FAIL pipe_reg: got %0d want 5", regEscrita); end
        total++; if (dadoEscrita !== 32'h11) begin bad++; $display("[TB] FAIL pipe_alu: got %h want 11", dadoEscrita); end
        drive(1, 5, 32'h77, 32'h22, 1, 0, 0, 0);
        step();
        total++; if (dadoEscrita !== 32'h22) begin bad++; $display("[TB] FAIL pipe_load: got %h want 22", dadoEscrita); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (escreveReg !== 1'b0) begin bad++; $display("[TB] FAIL pipe_idle: got %b want 0", escreveReg); end
    endtask

    task automatic test_bypass();
        drive(0, 0, 0, 0, 0, 1, 7, 32'hAB);
        step();
        total++; if (escreveReg !== 1'b1 || regEscrita !== 5'd7 || dadoEscrita !== 32'hAB) begin
            bad++; $display("[TB] FAIL bypass_write: got we=%b reg=%0d dado=%h want we=1 reg=7 dado=ab", escreveReg, regEscrita, dadoEscrita); end
        total++; if (md_pronto !== 1'b1 || pedeBolha !== 1'b0) begin
            bad++; $display("[TB] FAIL bypass_count: got pronto=%b bolha=%b want pronto=1 bolha=0", md_pronto, pedeBolha); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (escreveReg !== 1'b0) begin bad++; $display("[TB] FAIL bypass_noenq: got %b want 0", escreveReg); end
    endtask

    task automatic test_fill();
        drive(1, 10, 32'h100, 0, 0, 1, 3, 32'h33);
        step();
        total++; if (pedeBolha !== 1'b0 || md_pronto !== 1'b1) begin
            bad++; $display("[TB] FAIL fill_one: got bolha=%b pronto=%b want 0/1", pedeBolha, md_pronto); end
        drive(1, 10, 32'h101, 0, 0, 1, 4, 32'h44);
        step();
        total++; if (pedeBolha !== 1'b1 || md_pronto !== 1'b0) begin
            bad++; $display("[TB] FAIL fill_full: got bolha=%b pronto=%b want 1/0", pedeBolha, md_pronto); end
        // Pipeline ignores the bubble request while a third result is held.
        drive(1, 11, 32'h102, 0, 0, 1, 6, 32'h66);
        step();
        total++; if (escreveReg !== 1'b1 || regEscrita !== 5'd11 || dadoEscrita !== 32'h102) begin
            bad++; $display("[TB] FAIL fill_ignore: got we=%b reg=%0d dado=%h want 1/11/102", escreveReg, regEscrita, dadoEscrita); end
        total++; if (pedeBolha !== 1'b1 || md_pronto !== 1'b0) begin
            bad++; $display("[TB] FAIL fill_hold: got bolha=%b pronto=%b want 1/0", pedeBolha, md_pronto); end
        drive(0, 0, 0, 0, 0, 1, 6, 32'h66);
        step();
        total++; if (escreveReg !== 1'b1 || regEscrita !== 5'd3 || dadoEscrita !== 32'h33) begin
            bad++; $display("[TB] FAIL drain_first: got we=%b reg=%0d dado=%h want 1/3/33", escreveReg, regEscrita, dadoEscrita); end
        total++; if (pedeBolha !== 1'b0) begin bad++; $display("[TB] FAIL drain_bolha: got %b want 0", pedeBolha); end
        step();
        total++; if (escreveReg !== 1'b1 || regEscrita !== 5'd4 || dadoEscrita !== 32'h44) begin
            bad++; $display("[TB] FAIL drain_second: got we=%b reg=%0d dado=%h want 1/4/44", escreveReg, regEscrita, dadoEscrita); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (escreveReg !== 1'b1 || regEscrita !== 5'd6 || dadoEscrita !== 32'h66) begin
            bad++; $display("[TB] FAIL drain_third: got we=%b reg=%0d dado=%h want 1/6/66", escreveReg, regEscrita, dadoEscrita); end
        step();
        total++; if (escreveReg !== 1'b0 || pedeBolha !== 1'b0) begin
            bad++; $display("[TB] FAIL drain_empty: got we=%b bolha=%b want 0/0", escreveReg, pedeBolha); end
    endtask

    task automatic test_squash();
        drive(1, 2, 32'h200, 0, 0, 1, 9, 32'h55);
        step();
        drive(1, 9, 32'h66, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (escreveReg !== 1'b0) begin bad++; $display("[TB] FAIL squash_pop: got %b want 0", escreveReg); end
        step();
        total++; if (rf_dut[9] !== 32'h66) begin bad++; $display("[TB] FAIL squash_final: got %h want 66", rf_dut[9]); end
        drive(1, 9, 32'h77, 0, 0, 1, 9, 32'h88);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (escreveReg !== 1'b0) begin bad++; $display("[TB] FAIL squash_same: got %b want 0", escreveReg); end
        total++; if (rf_dut[9] !== 32'h77) begin bad++; $display("[TB] FAIL squash_same_final: got %h want 77", rf_dut[9]); end
    endtask

    task automatic test_reg0();
        drive(1, 0, 32'h300, 0, 0, 0, 0, 0);
        step();
        total++; if (escreveReg !== 1'b0) begin bad++; $display("[TB] FAIL reg0_nowrite: got %b want 0", escreveReg); end
        drive(1, 2, 32'h201, 0, 0, 1, 12, 32'hC);
        step();
        drive(1, 0, 32'h301, 0, 0, 0, 0, 0);
        step();
        total++; if (escreveReg !== 1'b1 || regEscrita !== 5'd12 || dadoEscrita !== 32'hC) begin
            bad++; $display("[TB] FAIL reg0_drain: got we=%b reg=%0d dado=%h want 1/12/c", escreveReg, regEscrita, dadoEscrita); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_reset_mid();
        drive(1, 2, 32'h202, 0, 0, 1, 13, 32'hD);
        step();
        drive(1, 2, 32'h203, 0, 0, 1, 14, 32'hE);
        step();
        total++; if (pedeBolha !== 1'b1) begin bad++; $display("[TB] FAIL rmid_full: got %b want 1", pedeBolha); end
        apply_reset(1);
        total++; if (escreveReg !== 1'b0 || regEscrita !== 5'd0 || dadoEscrita !== 32'd0 || pedeBolha !== 1'b0) begin
            bad++; $display("[TB] FAIL rmid_outputs: got we=%b reg=%0d dado=%h bolha=%b want all 0", escreveReg, regEscrita, dadoEscrita, pedeBolha); end
        total++; if (md_pronto !== 1'b1) begin bad++; $display("[TB] FAIL rmid_pronto: got %b want 1", md_pronto); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (escreveReg !== 1'b0) begin bad++; $display("[TB] FAIL rmid_stale%0d: got %b want 0", i, escreveReg); end
        end
    endtask

    task automatic test_random();
        bit wv, m2r;
        logic [RW-1:0] wr;
        for (int c = 0; c < 400; c++) begin
            wv  = ($urandom_range(0, 99) < 45);
            wr  = RW'($urandom_range(0, 7));
            m2r = $urandom_range(0, 1) == 1;
            // A refused offer stays on the bus unchanged until accepted.
            if (md_valido && !ultimo_hs)
                drive(wv, wr, $urandom, $urandom, m2r, 1, md_regDestino, md_dado);
            else
                drive(wv, wr, $urandom, $urandom, m2r, ($urandom_range(0, 99) < 60),
                      RW'($urandom_range(0, 7)), $urandom);
            total++; if (md_pronto !== (fila.size() < PROF)) begin
                bad++; $display("[TB] FAIL rnd_pronto c=%0d: got %b want %b", c, md_pronto, fila.size() < PROF); end
            step();
            total++; if (escreveReg !== exp_we) begin
                bad++; $display("[TB] FAIL rnd_we c=%0d: got %b want %b", c, escreveReg, exp_we); end
            total++; if (pedeBolha !== exp_bolha) begin
                bad++; $display("[TB] FAIL rnd_bolha c=%0d: got %b want %b", c, pedeBolha, exp_bolha); end
            if (exp_we) begin
                total++; if (regEscrita !== exp_reg || dadoEscrita !== exp_dado) begin
                    bad++; $display("[TB] FAIL rnd_data c=%0d: got reg=%0d dado=%h want reg=%0d dado=%h", c, regEscrita, dadoEscrita, exp_reg, exp_dado); end
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (PROF + 1) step();
        for (int r = 0; r < 32; r++) begin
            total++; if (rf_dut[r] !== rf_modelo[r]) begin
                bad++; $display("[TB] FAIL rnd_regfile r=%0d: got %h want %h", r, rf_dut[r], rf_modelo[r]); end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ultimo_hs = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rf_modelo[r] = '0;
            rf_dut[r]    = '0;
        end
        test_reset();
        test_pipeline();
        test_bypass();
        test_fill();
        test_squash();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
